iobuf_dir_ctrl: RTL and testbench

IOBUF_DIR_CTRL -- requirements
Module: iobuf_dir_ctrl

---
 rtl/iobuf_dir_ctrl.sv | 138 +++++++++++++
 tb/tb_iobuf_dir_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iobuf_dir_ctrl.sv
// Direction controller for a single tri-state pad: serialises write words onto the pad,
// samples read words from it, and enforces a release (turnaround) window after every drive.
module iobuf_dir_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TA_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             WR_VALID,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_READY,
  input  logic             RD_VALID,
  output logic             RD_READY,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_DONE,
  output logic             PAD_I,
  output logic             PAD_T,
  input  logic             PAD_O,
  output logic             BUSY
);

  // state  | meaning
  // IDLE   | pad released, waiting for a grant
  // DRIVE  | shifting the write word onto the pad, LSB first
  // TURN   | pad released for TA_CYCLES before anything else may happen
  // SAMPLE | pad released, capturing PAD_O into the read word, LSB first
  typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             pad_i_q, pad_i_d;
  logic             pad_t_q, pad_t_d;
  logic             rd_done_q, rd_done_d;
  logic             busy_q, busy_d;
  logic             last_wr_q, last_wr_d;
  logic             grant_wr, grant_rd;
  logic [WIDTH:0]   smp;

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant_wr = (state_q == IDLE) && EN && WR_VALID && (!RD_VALID || !last_wr_q);
    grant_rd = (state_q == IDLE) && EN && RD_VALID && (!WR_VALID || last_wr_q);
  end

  assign WR_READY = grant_wr;
  assign RD_READY = grant_rd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rd_data_d = rd_data_q;
    last_wr_d = last_wr_q;
    pad_i_d   = 1'b0;
    rd_done_d = 1'b0;
    smp       = {PAD_O, sh_q};

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d   = DRIVE;
          cnt_d     = 5'(WIDTH - 1);
          sh_d      = WR_DATA >> 1;
          pad_i_d   = WR_DATA[0];
          last_wr_d = 1'b1;
        end else if (grant_rd) begin
          state_d   = SAMPLE;
          cnt_d     = 5'(WIDTH - 1);
          sh_d      = '0;
          last_wr_d = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == 5'd0) begin
          state_d = (TA_CYCLES > 0) ? TURN : IDLE;
          cnt_d   = 5'(TA_CYCLES - 1);
        end else begin
          cnt_d   = cnt_q - 5'd1;
          pad_i_d = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      TURN: begin
        if (cnt_q == 5'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 5'd1;
      end
      SAMPLE: begin
        // New bit enters at the top so the first sample ends up in bit 0.
        sh_d = smp[WIDTH:1];
        if (cnt_q == 5'd0) begin
          state_d   = IDLE;
          rd_data_d = smp[WIDTH:1];
          rd_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    pad_t_d = (state_d != DRIVE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rd_data_q <= '0;
      pad_i_q   <= 1'b0;
      pad_t_q   <= 1'b1;
      rd_done_q <= 1'b0;
      busy_q    <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rd_data_q <= rd_data_d;
      pad_i_q   <= pad_i_d;
      pad_t_q   <= pad_t_d;
      rd_done_q <= rd_done_d;
      busy_q    <= busy_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign RD_DATA = rd_data_q;
  assign RD_DONE = rd_done_q;
  assign PAD_I   = pad_i_q;
  assign PAD_T   = pad_t_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_iobuf_dir_ctrl.sv
// Bench for iobuf_dir_ctrl: directed transfers with a queue-based scoreboard on the
// TA=2 instance, plus a direct sequence check on a TA=0 instance.
module tb_iobuf_dir_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, wr_valid, rd_valid, pad_o;
  logic [7:0] wr_data;
  logic       wr_ready, rd_ready, rd_done, pad_i, pad_t, busy;
  logic [7:0] rd_data;

  logic       en2, wv2, rv2, po2;
  logic [7:0] wd2;
  logic       wr_ready2, rd_ready2, rd_done2, pad_i2, pad_t2, busy2;
  logic [7:0] rd_data2;

  iobuf_dir_ctrl #(.WIDTH(8), .TA_CYCLES(2)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en),
    .WR_VALID(wr_valid), .WR_DATA(wr_data), .WR_READY(wr_ready),
    .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_DATA(rd_data), .RD_DONE(rd_done),
    .PAD_I(pad_i), .PAD_T(pad_t), .PAD_O(pad_o), .BUSY(busy)
  );

  iobuf_dir_ctrl #(.WIDTH(8), .TA_CYCLES(0)) dut_ta0 (
    .CLK(clk), .RST_N(rst_n), .EN(en2),
    .WR_VALID(wv2), .WR_DATA(wd2), .WR_READY(wr_ready2),
    .RD_VALID(rv2), .RD_READY(rd_ready2), .RD_DATA(rd_data2), .RD_DONE(rd_done2),
    .PAD_I(pad_i2), .PAD_T(pad_t2), .PAD_O(po2), .BUSY(busy2)
  );

  int checks   = 0;
  int failures = 0;
  logic       exp_bits[$];
  logic [7:0] exp_words[$];

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every driven pad bit and every completed read word is matched against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk1("ready_exclusive", wr_ready && rd_ready, 1'b0);
      if (pad_t === 1'b0) begin
        chk1("drive_expected", exp_bits.size() != 0, 1'b1);
        if (exp_bits.size() != 0) chk1("pad_i_bit", pad_i, exp_bits.pop_front());
      end
      if (rd_done === 1'b1) begin
        chk1("done_expected", exp_words.size() != 0, 1'b1);
        if (exp_words.size() != 0) chkw("rd_data_word", 32'(rd_data), 32'(exp_words.pop_front()));
      end
    end
  end

  task automatic do_write(input logic [7:0] d);
    bit ok = 1'b0;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (wr_ready) ok = 1'b1;
      else @(negedge clk);
    end
    chk1("wr_grant", ok, 1'b1);
    if (!ok) begin
      wr_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 8; k++) exp_bits.push_back(d[k]);
    @(posedge clk); #1 wr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("drive_pad_t", pad_t, 1'b0);
    end
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      chk1("turn_pad_t", pad_t, 1'b1);
      chk1("turn_pad_i", pad_i, 1'b0);
      chk1("turn_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk1("idle_after_write", busy, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] pat, input logic [7:0] expw, input bit drop_en);
    bit ok = 1'b0;
    rd_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (rd_ready) ok = 1'b1;
      else @(negedge clk);
    end
    chk1("rd_grant", ok, 1'b1);
    if (!ok) begin
      rd_valid = 1'b0;
      return;
    end
    exp_words.push_back(expw);
    @(posedge clk); #1 rd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pad_o = pat[k];
      chk1("sample_pad_t", pad_t, 1'b1);
      chk1("sample_busy", busy, 1'b1);
      if (drop_en && k == 2) en = 1'b0;
    end
    @(negedge clk);
    chk1("rd_done_pulse", rd_done, 1'b1);
    chk1("idle_at_done", busy, 1'b0);
    @(negedge clk);
    chk1("rd_done_single", rd_done, 1'b0);
    chkw("rd_data_hold", 32'(rd_data), 32'(expw));
    en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  ok;
    rst_n = 1'b1; en = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; wr_data = '0; pad_o = 1'b0;
    en2 = 1'b1; wv2 = 1'b0; rv2 = 1'b0; wd2 = '0; po2 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_pad_t", pad_t, 1'b1);
    chk1("rst_pad_i", pad_i, 1'b0);
    chkw("rst_rd_data", 32'(rd_data), 32'h0);
    chk1("rst_rd_done", rd_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // EN low blocks every grant
    en = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk1("en0_wr_ready", wr_ready, 1'b0);
      chk1("en0_rd_ready", rd_ready, 1'b0);
      chk1("en0_busy", busy, 1'b0);
    end
    wr_valid = 1'b0; rd_valid = 1'b0; en = 1'b1;
    @(negedge clk);

    do_write(8'hA5);
    do_read(8'b1100_0110, 8'hC6, 1'b0);
    do_read(8'b0011_1011, 8'h3B, 1'b1);
    do_write(8'h81);

    // Reset during DRIVE bit 3, then a clean write restarts from bit 0
    wr_data = 8'hFF; wr_valid = 1'b1;
    #1 chk1("abort_wr_grant", wr_ready, 1'b1);
    for (int k = 0; k < 8; k++) exp_bits.push_back(1'b1);
    @(posedge clk); #1 wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_wr_pad_t", pad_t, 1'b1);
    chk1("abort_wr_pad_i", pad_i, 1'b0);
    chk1("abort_wr_busy", busy, 1'b0);
    exp_bits.delete();
    @(negedge clk) rst_n = 1'b1;
    do_write(8'h5A);

    // Reset during SAMPLE discards the read
    rd_valid = 1'b1;
    #1 chk1("abort_rd_grant", rd_ready, 1'b1);
    @(posedge clk); #1 rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_rd_busy", busy, 1'b0);
    chk1("abort_rd_pad_t", pad_t, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_done) cnt++;
    end
    chkw("abort_rd_no_done", 32'(cnt), 32'd0);

    // Contention from reset: W,R,W,R
    #2 rst_n = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1; wr_data = 8'h3C; pad_o = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    #1 chk1("first_grant_write", wr_ready, 1'b1);
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
        if (wr_ready || rd_ready) ok = 1'b1;
        else begin
          @(negedge clk); #1;
        end
      end
      chk1("contention_grant", ok, 1'b1);
      if (!ok) break;
      chk1("grant_order", wr_ready, (g % 2) == 0);
      if (wr_ready) for (int k = 0; k < 8; k++) exp_bits.push_back(wr_data[k]);
      else          exp_words.push_back(8'hFF);
      @(posedge clk);
      if (g == 3) begin
        #1 wr_valid = 1'b0; rd_valid = 1'b0;
      end else begin
        @(negedge clk); #1;
      end
    end
    repeat (20) @(negedge clk);
    chkw("sb_drained", 32'(exp_bits.size() + exp_words.size()), 32'd0);

    // TA_CYCLES=0: DRIVE, one IDLE cycle, then SAMPLE
    wd2 = 8'h96; wv2 = 1'b1; rv2 = 1'b1; po2 = 1'b1;
    #1 chk1("ta0_wr_first", wr_ready2, 1'b1);
    @(posedge clk); #1 wv2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("ta0_drive_pad_t", pad_t2, 1'b0);
      chk1("ta0_drive_pad_i", pad_i2, wd2[k]);
    end
    @(negedge clk);
    chk1("ta0_idle_busy", busy2, 1'b0);
    chk1("ta0_idle_pad_t", pad_t2, 1'b1);
    chk1("ta0_rd_ready", rd_ready2, 1'b1);
    @(posedge clk); #1 rv2 = 1'b0;
    @(negedge clk);
    chk1("ta0_sample_busy", busy2, 1'b1);
    chk1("ta0_sample_pad_t", pad_t2, 1'b1);
    repeat (7) @(negedge clk);
    @(negedge clk);
    chk1("ta0_rd_done", rd_done2, 1'b1);
    chkw("ta0_rd_data", 32'(rd_data2), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
